// File: rtl/interval_timer_arbiter_pkg.sv
// Shared types and helpers for the round-robin interval timer arbiter.
// Holds the FSM state encoding and the rotating-priority pick function.
package interval_timer_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int MAX_REQ = 32;

   // Returns the first set bit at or after ptr (wrapping within n), or -1 when none is set.
   // Scanning from the far end lets the nearest candidate overwrite earlier hits.
   function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
      int sel;
      int idx;
      sel = -1;
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         if (k < n) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (req[idx[4:0]]) sel = idx;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/interval_timer_arbiter_if.sv
// Request/grant bundle between the requesting blocks and the shared interval timer.
interface interval_timer_arbiter_if #(
   parameter int COUNT = 4,
   parameter int NREQ  = 4
);
   logic [NREQ-1:0]       req;
   logic [NREQ*COUNT-1:0] interval;
   logic [NREQ-1:0]       grant;
   logic [NREQ-1:0]       done;
   logic                  busy;
   logic [COUNT-1:0]      cnt;

   modport master (
      output req, interval,
      input  grant, done, busy, cnt
   );

   modport slave (
      input  req, interval,
      output grant, done, busy, cnt
   );
endinterface

// File: rtl/interval_timer_arbiter_counter.sv
// Loadable down-counter that parks at zero instead of wrapping.
module load_down_counter #(
   parameter int COUNT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [COUNT-1:0] load_val,
   input  logic             en,
   output logic [COUNT-1:0] cnt,
   output logic             zero
);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/interval_timer_arbiter.sv
// Shares one down-counting interval timer among NREQ requesters using round-robin arbitration.
// Each granted job runs for interval+1 cycles, then pulses done for one cycle to its owner.
module interval_timer_arbiter
   import interval_timer_arbiter_pkg::*;
#(
   parameter int COUNT = 4,
   parameter int NREQ  = 4
) (
   input logic                     clk,
   input logic                     reset,
   interval_timer_arbiter_if.slave bus
);

   localparam int PW = $clog2(NREQ);

   state_t           state, state_nxt;
   logic [NREQ-1:0]  grant_q, grant_nxt;
   logic [NREQ-1:0]  done_q, done_nxt;
   logic [PW-1:0]    ptr_q, ptr_nxt;
   logic [PW-1:0]    owner_q, owner_nxt;
   logic [PW-1:0]    ptr_after;
   logic [PW-1:0]    pick_idx;
   int               pick;
   logic             ld;
   logic [COUNT-1:0] ld_val;
   logic             en;
   logic             zero;
   logic [COUNT-1:0] cnt;
   logic [COUNT-1:0] ivl [NREQ];

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         ivl[i] = bus.interval[i*COUNT +: COUNT];
      end
   end

   // Priority rotates to the requester just after whoever last held the timer.
   assign ptr_after = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

   load_down_counter #(.COUNT(COUNT)) u_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (ld),
      .load_val (ld_val),
      .en       (en),
      .cnt      (cnt),
      .zero     (zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         grant_q <= '0;
         done_q  <= '0;
         ptr_q   <= '0;
         owner_q <= '0;
      end else begin
         state   <= state_nxt;
         grant_q <= grant_nxt;
         done_q  <= done_nxt;
         ptr_q   <= ptr_nxt;
         owner_q <= owner_nxt;
      end
   end

   // A dropped owner request aborts the job and clears the timer; it takes precedence over completion.
   always_comb begin
      state_nxt = state;
      grant_nxt = grant_q;
      done_nxt  = '0;
      ptr_nxt   = ptr_q;
      owner_nxt = owner_q;
      ld        = 1'b0;
      ld_val    = '0;
      en        = 1'b0;
      pick      = rr_pick(MAX_REQ'(bus.req), int'(ptr_q), NREQ);
      pick_idx  = pick[PW-1:0];
      unique case (state)
         ST_IDLE: begin
            grant_nxt = '0;
            if (pick >= 0) begin
               state_nxt = ST_RUN;
               owner_nxt = pick_idx;
               grant_nxt = NREQ'(1) << pick_idx;
               ld        = 1'b1;
               ld_val    = ivl[pick_idx];
            end
         end
         ST_RUN: begin
            if (!bus.req[owner_q]) begin
               state_nxt = ST_IDLE;
               grant_nxt = '0;
               ld        = 1'b1;
               ld_val    = '0;
               ptr_nxt   = ptr_after;
            end else if (zero) begin
               state_nxt = ST_DONE;
               done_nxt  = grant_q;
            end else begin
               en = 1'b1;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
            grant_nxt = '0;
            ptr_nxt   = ptr_after;
         end
         default: begin
            state_nxt = ST_IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   assign bus.grant = grant_q;
   assign bus.done  = done_q;
   assign bus.busy  = (state == ST_RUN) || (state == ST_DONE);
   assign bus.cnt   = cnt;

endmodule
